// File: rtl/instr_ring_buffer.sv
// Circular instruction buffer between fetch and decode/issue, with flush and look-ahead peek.
// Latency: enqueue to out_valid 1 cycle (no bypass); head is first-word-fall-through; peek is registered (1 cycle).
// Backpressure: in_ready drops when full or flushing; a pop while full frees space only on the next cycle.
module instr_ring_buffer #(
  parameter int INSTR_W   = 32,
  parameter int DEPTH     = 16,
  parameter int DROP_NULL = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [INSTR_W-1:0]         in_instr,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [INSTR_W-1:0]         out_instr,
  input  logic                       out_ready,
  input  logic                       flush,
  input  logic [$clog2(DEPTH)-1:0]   peek_index,
  output logic [INSTR_W-1:0]         peek_instr,
  output logic                       peek_valid,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [AW:0]        count_q;
  logic [DEPTH-1:0]   valid_q;
  logic [INSTR_W-1:0] mem [DEPTH];

  logic               push;
  logic               is_null;
  logic               store;
  logic               pop;
  logic [AW-1:0]      peek_addr;

  // Handshake decode; a dropped null word completes the handshake but is never stored.
  always_comb begin
    full      = (count_q == FULL_CNT);
    empty     = (count_q == '0);
    count     = count_q;
    in_ready  = !full && !flush;
    push      = in_valid && in_ready;
    is_null   = (DROP_NULL != 0) && (in_instr == '0);
    store     = push && !is_null;
    out_valid = valid_q[rd_ptr];
    out_instr = mem[rd_ptr];
    pop       = out_valid && out_ready && !flush;
    peek_addr = rd_ptr + peek_index;
  end

  // Pointers, occupancy and per-entry valid bits; flush returns everything to the reset layout.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      if (store) begin
        valid_q[wr_ptr] <= 1'b1;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) begin
        valid_q[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + 1'b1;
      end
      case ({store, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Data array has no reset; only slots marked valid are ever observed as live.
  always_ff @(posedge clk) begin
    if (!rst && store) begin
      mem[wr_ptr] <= in_instr;
    end
  end

  // Look-ahead read sampled against the pre-edge head and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      peek_instr <= '0;
      peek_valid <= 1'b0;
    end else begin
      peek_instr <= mem[peek_addr];
      peek_valid <= ({1'b0, peek_index} < count_q) && !flush;
    end
  end

endmodule
